// File: rtl/clk_step_pkg.sv
// Shared types for the pipeline clock-enable controller.
package clk_step_pkg;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_STEP = 2'b01,
        MODE_RUN  = 2'b10,
        MODE_FAST = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_RUN,
        ST_FAST,
        ST_BREAK
    } state_e;

    localparam int SYNC_DEPTH = 2;

    function automatic state_e mode_to_state(mode_e m);
        state_e s;
        case (m)
            MODE_STEP: s = ST_STEP;
            MODE_RUN:  s = ST_RUN;
            MODE_FAST: s = ST_FAST;
            default:   s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/clk_step_ctrl_if.sv
// Control/status bundle between the clock-enable controller and its user.
interface clk_step_ctrl_if #(parameter int CNT_W = 26);
    import clk_step_pkg::*;

    mode_e             mode;
    logic              btn_step;
    logic [CNT_W-1:0]  rate_div;
    logic              halt_req;
    logic              cpu_en;
    logic              running;
    logic              in_break;
    logic [31:0]       step_count;

    modport master (
        output mode, btn_step, rate_div, halt_req,
        input  cpu_en, running, in_break, step_count
    );

    modport slave (
        input  mode, btn_step, rate_div, halt_req,
        output cpu_en, running, in_break, step_count
    );

endinterface

// File: rtl/clk_step_ctrl_btn_debounce.sv
// Push-button synchronizer, debouncer and registered rising-edge detector.
module btn_debounce
    import clk_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  level_prev_q;
    logic                  rise_q;

    // Counts consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[SYNC_DEPTH-1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_DEPTH-2:0], btn_in};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            rise_q       <= level_q & ~level_prev_q;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Single-domain clock-enable generator for the 3-stage pipeline.
//   state    | meaning
//   ST_IDLE  | halted, no enables
//   ST_STEP  | one enable per debounced button press
//   ST_RUN   | one enable every rate_div cycles
//   ST_FAST  | enable every cycle
//   ST_BREAK | frozen by halt_req; button still single-steps; leave via mode 00
module clk_step_ctrl
    import clk_step_pkg::*;
#(
    parameter int CNT_W           = 26,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    clk_step_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic [CNT_W-1:0]  rate_q, rate_d;
    logic              cpu_en_q, cpu_en_d;
    logic [31:0]       step_count_q, step_count_d;
    logic              btn_rise;
    logic              btn_level;
    logic              step_pulse;
    logic              run_tc;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (bus.btn_step),
        .level_out  (btn_level),
        .rise_pulse (btn_rise)
    );

    assign step_pulse = btn_rise & btn_level;

    // Periods of 0 and 1 both mean "every cycle".
    assign run_tc = (rate_q <= CNT_W'(1)) || (rcnt_q >= (rate_q - CNT_W'(1)));

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        rcnt_d   = '0;
        rate_d   = rate_q;
        case (state_q)
            ST_BREAK: begin
                if (bus.mode == MODE_HALT) begin
                    state_d = ST_IDLE;
                end else begin
                    cpu_en_d = step_pulse;
                end
            end
            default: begin
                state_d = mode_to_state(bus.mode);
                if (bus.halt_req && (state_q != ST_IDLE)) begin
                    state_d = ST_BREAK;
                end else if (state_d == state_q) begin
                    // Pulses only while staying put: a mode change drops any pending enable.
                    case (state_q)
                        ST_STEP: cpu_en_d = step_pulse;
                        ST_FAST: cpu_en_d = 1'b1;
                        ST_RUN: begin
                            if (run_tc) begin
                                cpu_en_d = 1'b1;
                                rate_d   = bus.rate_div;
                            end else begin
                                rcnt_d = rcnt_q + CNT_W'(1);
                            end
                        end
                        default: cpu_en_d = 1'b0;
                    endcase
                end else if (state_d == ST_RUN) begin
                    rate_d = bus.rate_div;
                end
            end
        endcase
    end

    assign step_count_d = step_count_q + {31'b0, cpu_en_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rcnt_q       <= '0;
            rate_q       <= '0;
            cpu_en_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            rate_q       <= rate_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.running    = (state_q == ST_RUN) || (state_q == ST_FAST);
    assign bus.in_break   = (state_q == ST_BREAK);
    assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl with DEBOUNCE_CYCLES=16.
module tb_clk_step_ctrl;
    import clk_step_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    clk_step_ctrl_if #(.CNT_W(26)) bus ();

    clk_step_ctrl #(
        .CNT_W           (26),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset;
        reset        = 1'b1;
        bus.mode     = MODE_HALT;
        bus.btn_step = 1'b0;
        bus.rate_div = '0;
        bus.halt_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests++; if (bus.cpu_en !== 1'b0) begin fails++; $display("FAIL reset_cpu_en got %b want 0", bus.cpu_en); end
        tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL reset_running got %b want 0", bus.running); end
        tests++; if (bus.in_break !== 1'b0) begin fails++; $display("FAIL reset_in_break got %b want 0", bus.in_break); end
        tests++; if (bus.step_count !== 32'd0) begin fails++; $display("FAIL reset_step_count got %0d want 0", bus.step_count); end
    endtask

    task automatic test_step_press;
        int n = 0;
        int first = -1;
        do_reset();
        bus.mode = MODE_STEP;
        @(negedge clk);
        bus.btn_step = 1'b1;
        for (int e = 0; e < 70; e++) begin
            @(posedge clk); #1;
            if (bus.cpu_en) begin n++; if (first < 0) first = e; end
            if (e == 40) bus.btn_step = 1'b0;
        end
        tests++; if (n != 1) begin fails++; $display("FAIL step_press_count got %0d want 1", n); end
        tests++; if (first != 19) begin fails++; $display("FAIL step_press_latency got %0d want 19", first); end
        tests++; if (bus.step_count !== 32'd1) begin fails++; $display("FAIL step_press_step_count got %0d want 1", bus.step_count); end
    endtask

    task automatic test_bounce;
        int n = 0;
        int first = -1;
        do_reset();
        bus.mode = MODE_STEP;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.btn_step = (i < 60) ? (((i / 5) % 2) == 0) : 1'b1;
            @(posedge clk); #1;
            if (bus.cpu_en) begin n++; if (first < 0) first = i; end
        end
        bus.btn_step = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_en) n++;
        end
        tests++; if (n != 1) begin fails++; $display("FAIL bounce_count got %0d want 1", n); end
        tests++; if (first != 79) begin fails++; $display("FAIL bounce_latency got %0d want 79", first); end
        tests++; if (bus.step_count !== 32'd1) begin fails++; $display("FAIL bounce_step_count got %0d want 1", bus.step_count); end
    endtask

    task automatic test_idle_ignores;
        int n = 0;
        do_reset();
        bus.btn_step = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (bus.cpu_en) n++;
        end
        bus.btn_step = 1'b0;
        repeat (24) @(posedge clk);
        tests++; if (n != 0) begin fails++; $display("FAIL idle_press_count got %0d want 0", n); end
        tests++; if (bus.step_count !== 32'd0) begin fails++; $display("FAIL idle_step_count got %0d want 0", bus.step_count); end
    endtask

    task automatic test_run_rate;
        int n = 0;
        int first = -1;
        int last = -1;
        int bad = 0;
        do_reset();
        bus.rate_div = 26'd4;
        @(negedge clk);
        bus.mode = MODE_RUN;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (bus.cpu_en) begin
                n++;
                if (first < 0) first = e;
                if (last >= 0 && (e - last) != 4) bad++;
                last = e;
            end
        end
        tests++; if (n != 9) begin fails++; $display("FAIL run4_count got %0d want 9", n); end
        tests++; if (first != 5) begin fails++; $display("FAIL run4_first got %0d want 5", first); end
        tests++; if (bad != 0) begin fails++; $display("FAIL run4_spacing got %0d bad gaps want 0", bad); end
        tests++; if (bus.running !== 1'b1) begin fails++; $display("FAIL run4_running got %b want 1", bus.running); end
        tests++; if (bus.step_count !== 32'd9) begin fails++; $display("FAIL run4_step_count got %0d want 9", bus.step_count); end
    endtask

    task automatic test_continuous;
        int n0 = 0;
        int n1 = 0;
        int nf = 0;
        do_reset();
        bus.rate_div = 26'd0;
        @(negedge clk);
        bus.mode = MODE_RUN;
        @(posedge clk);
        for (int e = 0; e < 20; e++) begin @(posedge clk); #1; if (bus.cpu_en) n0++; end
        @(negedge clk);
        bus.rate_div = 26'd1;
        for (int e = 0; e < 20; e++) begin @(posedge clk); #1; if (bus.cpu_en) n1++; end
        @(negedge clk);
        bus.mode = MODE_FAST;
        @(posedge clk);
        for (int e = 0; e < 20; e++) begin @(posedge clk); #1; if (bus.cpu_en) nf++; end
        tests++; if (n0 != 20) begin fails++; $display("FAIL run0_continuous got %0d want 20", n0); end
        tests++; if (n1 != 20) begin fails++; $display("FAIL run1_continuous got %0d want 20", n1); end
        tests++; if (nf != 20) begin fails++; $display("FAIL fast_continuous got %0d want 20", nf); end
        tests++; if (bus.running !== 1'b1) begin fails++; $display("FAIL fast_running got %b want 1", bus.running); end
    endtask

    task automatic test_halt_break;
        int n = 0;
        int first = -1;
        int held = 0;
        do_reset();
        @(negedge clk);
        bus.mode = MODE_FAST;
        for (int c = 1; c <= 9; c++) begin @(posedge clk); #1; end
        tests++; if (bus.cpu_en !== 1'b1) begin fails++; $display("FAIL fast_before_halt got %b want 1", bus.cpu_en); end
        bus.halt_req = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.cpu_en !== 1'b0) begin fails++; $display("FAIL halt_cpu_en got %b want 0", bus.cpu_en); end
        tests++; if (bus.in_break !== 1'b1) begin fails++; $display("FAIL halt_in_break got %b want 1", bus.in_break); end
        tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL halt_running got %b want 0", bus.running); end
        for (int c = 0; c < 5; c++) begin @(posedge clk); #1; if (bus.cpu_en) held++; end
        tests++; if (held != 0) begin fails++; $display("FAIL break_quiet got %0d pulses want 0", held); end
        tests++; if (bus.step_count !== 32'd8) begin fails++; $display("FAIL break_step_count got %0d want 8", bus.step_count); end
        bus.btn_step = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (bus.cpu_en) begin n++; if (first < 0) first = e; end
        end
        bus.btn_step = 1'b0;
        for (int e = 0; e < 24; e++) begin @(posedge clk); #1; if (bus.cpu_en) n++; end
        tests++; if (n != 1) begin fails++; $display("FAIL break_step_count_pulses got %0d want 1", n); end
        tests++; if (first != 19) begin fails++; $display("FAIL break_step_latency got %0d want 19", first); end
        tests++; if (bus.step_count !== 32'd9) begin fails++; $display("FAIL break_step_total got %0d want 9", bus.step_count); end
        bus.mode = MODE_HALT;
        @(posedge clk); #1;
        tests++; if (bus.in_break !== 1'b0) begin fails++; $display("FAIL break_exit_in_break got %b want 0", bus.in_break); end
        tests++; if (bus.cpu_en !== 1'b0) begin fails++; $display("FAIL break_exit_cpu_en got %b want 0", bus.cpu_en); end
        bus.halt_req = 1'b0;
    endtask

    task automatic test_halt_vs_step;
        do_reset();
        bus.mode = MODE_STEP;
        @(negedge clk);
        bus.btn_step = 1'b1;
        for (int e = 0; e <= 18; e++) begin @(posedge clk); #1; end
        bus.halt_req = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.cpu_en !== 1'b0) begin fails++; $display("FAIL halt_vs_step_cpu_en got %b want 0", bus.cpu_en); end
        tests++; if (bus.in_break !== 1'b1) begin fails++; $display("FAIL halt_vs_step_in_break got %b want 1", bus.in_break); end
        tests++; if (bus.step_count !== 32'd0) begin fails++; $display("FAIL halt_vs_step_count got %0d want 0", bus.step_count); end
        bus.btn_step = 1'b0;
        bus.mode     = MODE_HALT;
        bus.halt_req = 1'b0;
        repeat (24) @(posedge clk);
    endtask

    task automatic test_step_count_wrap;
        int  waited = 0;
        logic seen = 1'b0;
        do_reset();
        force dut.step_count_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.step_count_q;
        @(posedge clk); #1;
        tests++; if (bus.step_count !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_preload got %h want ffffffff", bus.step_count); end
        bus.mode = MODE_FAST;
        while (!seen && waited < 10) begin
            @(posedge clk); #1;
            waited++;
            if (bus.cpu_en) seen = 1'b1;
        end
        bus.mode = MODE_HALT;
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL wrap_pulse_timeout got %b want 1", seen); end
        tests++; if (bus.step_count !== 32'd0) begin fails++; $display("FAIL wrap_step_count got %h want 00000000", bus.step_count); end
    endtask

    task automatic test_reset_mid_run;
        int   waited = 0;
        logic seen = 1'b0;
        int   early = 0;
        do_reset();
        bus.rate_div = 26'd3;
        @(negedge clk);
        bus.mode = MODE_RUN;
        while (!seen && waited < 20) begin
            @(posedge clk); #1;
            waited++;
            if (bus.cpu_en) seen = 1'b1;
        end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL midrun_pulse_timeout got %b want 1", seen); end
        #1 reset = 1'b1;
        #1;
        tests++; if (bus.cpu_en !== 1'b0) begin fails++; $display("FAIL midrun_reset_cpu_en got %b want 0", bus.cpu_en); end
        tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL midrun_reset_running got %b want 0", bus.running); end
        tests++; if (bus.step_count !== 32'd0) begin fails++; $display("FAIL midrun_reset_step_count got %0d want 0", bus.step_count); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin @(posedge clk); #1; if (bus.cpu_en) early++; end
        @(posedge clk); #1;
        tests++; if (early != 0) begin fails++; $display("FAIL midrun_release_early got %0d pulses want 0", early); end
        tests++; if (bus.cpu_en !== 1'b1) begin fails++; $display("FAIL midrun_release_first got %b want 1", bus.cpu_en); end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        bus.mode     = MODE_HALT;
        bus.btn_step = 1'b0;
        bus.rate_div = '0;
        bus.halt_req = 1'b0;
        test_reset();
        test_step_press();
        test_bounce();
        test_idle_ignores();
        test_run_rate();
        test_continuous();
        test_halt_break();
        test_halt_vs_step();
        test_step_count_wrap();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_step_ctrl.md
Name: clk_step_ctrl

Overview:
- Replaces the ripple divided-clock scheme with a single-clock-domain clock-enable controller for the 3-stage pipeline on FPGA.
- Generates a registered one-cycle `cpu_en` pulse that gates every pipeline register.
- Modes: halt, manual single-step (debounced push-button), run at programmable rate, and full-speed run.
- Honours a break request from the datapath so execution can be frozen and inspected.

Parameters:
- CNT_W, 26, width of the run-rate counter and of `rate_div`.
- DEBOUNCE_CYCLES, 16, number of consecutive equal synchronized samples required to accept a new button level. Set 500000 on the board.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  2  00 HALT, 01 STEP, 10 RUN (divided), 11 FAST (every cycle). Synchronous to clk.
- btn_step  in  1  raw push-button, asynchronous, bouncy.
- rate_div  in  CNT_W  RUN-mode period in cycles. Sampled when the counter reloads.
- halt_req  in  1  break request from the datapath (breakpoint/ecall), level.
- cpu_en  out  1  registered one-cycle enable pulse to the pipeline.
- running  out  1  high while state is RUN or FAST.
- in_break  out  1  high while state is BREAK.
- step_count  out  32  number of `cpu_en` pulses issued; wraps 0xFFFFFFFF -> 0.

Behaviour:
- Reset: all registers clear asynchronously.
  - `cpu_en`=0, `running`=0, `in_break`=0, `step_count`=0.
  - state=IDLE, rate counter=0, synchronizer=0, debounced level=0, debounce counter=0.
- Button path:
  - 2-flop synchronizer feeds the debouncer.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it. Any matching sample clears the count.
  - Rising edge of the debounced level gives a single-cycle `step_pulse`.
  - Latency: a clean press produces `cpu_en` exactly DEBOUNCE_CYCLES+3 rising edges after the first edge at which `btn_step` is sampled high.
  - A glitch shorter than DEBOUNCE_CYCLES produces nothing.
- FSM states: IDLE, STEP, RUN, FAST, BREAK. Decoded from `mode` each cycle unless in BREAK.
  - IDLE (mode 00): `cpu_en`=0; step pulses are ignored.
  - STEP (mode 01): each `step_pulse` gives exactly one `cpu_en` on the next cycle.
  - RUN (mode 10): rate counter counts 0..rate_div-1, then reloads to 0.
    - `cpu_en`=1 in the cycle after the counter equals rate_div-1.
    - rate_div of 0 or 1 gives `cpu_en` every cycle.
    - The counter resets to 0 on every entry into RUN.
  - FAST (mode 11): `cpu_en`=1 every cycle while in the state.
  - BREAK: entered from STEP, RUN or FAST when `halt_req`=1.
    - A `cpu_en` pulse due in that same cycle is suppressed (halt wins).
    - In BREAK, `cpu_en`=0 except that `step_pulse` still issues single steps, for stepping past a breakpoint.
    - `halt_req` is ignored while in BREAK.
    - Exit only when `mode`=00 (to IDLE).
    - `in_break`=1 throughout.
- Mode change mid-operation:
  - Takes effect on the next edge.
  - A pending RUN count is discarded.
  - Switching to IDLE never emits a trailing pulse.
- Simultaneous `step_pulse` and `halt_req` in STEP: halt wins, no pulse, enter BREAK.
- `step_count` increments in the same cycle `cpu_en` is high, so both update on the same edge.
- Reset asserted mid-run drops `cpu_en` immediately (asynchronous), with no partial pulse after release.
- `cpu_en` is never high for two consecutive cycles except in FAST, or in RUN with rate_div<=1.

Decomposition:
- Package clk_step_pkg:
  - `mode_e` enum (HALT=2'b00, STEP=2'b01, RUN=2'b10, FAST=2'b11).
  - `state_e` enum (IDLE, STEP, RUN, FAST, BREAK).
  - Localparam for the synchronizer depth (2).
- Sub-module `btn_debounce`:
  - Contains the synchronizer, debounce counter and rising-edge detector.
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, reset, btn_in, level_out, rise_pulse.
- The top level holds the FSM, the rate counter and `step_count`.

Test Plan:
- Reset, then mode=01, then a clean press held for 40 cycles (DEBOUNCE_CYCLES=16) -> exactly one `cpu_en` at edge 19 after first high sample; `step_count`=1.
- mode=01, button bouncing 1/0 every 5 cycles for 60 cycles, then stable high -> exactly one `cpu_en`, 19 edges after stable high begins.
- mode=10, rate_div=4, run 40 cycles -> `cpu_en` every 4th cycle, `step_count`=10 ±1 edge alignment, `running`=1.
- mode=10, rate_div=0 and then 1 -> `cpu_en` continuously high; mode=11 -> same.
- mode=11, `halt_req`=1 at cycle 10 -> `cpu_en`=0 from cycle 10, `in_break`=1, `running`=0.
  - A step press gives one pulse.
  - mode=00 -> IDLE, `in_break`=0.
- `step_count` preloaded by running 2^32-1 pulses (forced via hierarchical init), one more pulse -> `step_count`=0.
- Reset asserted mid-RUN -> outputs 0 asynchronously, and no pulse for rate_div cycles after release in RUN.
